// File: rtl/toggle_pulse_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_pulse_debouncer
//  Description : Synchronises and debounces a raw push-button level and emits
//                one single-cycle toggle pulse per accepted press. It also
//                exposes the debounced level and a wrapping 8-bit press count.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_pulse_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       toggle_pulse,
   output logic [7:0] press_count
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_ST_IDLE_LOW   = 2'd0;
   localparam logic [1:0] c_ST_CHECK_HIGH = 2'd1;
   localparam logic [1:0] c_ST_IDLE_HIGH  = 2'd2;
   localparam logic [1:0] c_ST_CHECK_LOW  = 2'd3;

   localparam logic [CNT_WIDTH-1:0] c_CNT_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO  = '0;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   w_s;

   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   w_cnt_done;

   logic                   btn_level_q;
   logic                   btn_level_d;
   logic                   toggle_pulse_q;
   logic                   toggle_pulse_d;
   logic [7:0]             press_count_q;
   logic [7:0]             press_count_d;

   // ------------------------------------------------------------------------
   // Synchroniser: bit 0 captures the raw pin, the top bit is the sampled
   // level the FSM works on. It keeps shifting even while ena is low so the
   // FSM never resumes on a stale sample.
   // ------------------------------------------------------------------------
   assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
   assign w_s    = sync_q[SYNC_STAGES-1];

   // Synchroniser chain register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // The current candidate level has been seen DEBOUNCE_CYCLES times already;
   // one more matching sample completes acceptance.
   assign w_cnt_done = (cnt_q == c_CNT_LIMIT);

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= c_ST_IDLE_LOW;
         cnt_q          <= c_CNT_ZERO;
         btn_level_q    <= 1'b0;
         toggle_pulse_q <= 1'b0;
         press_count_q  <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         btn_level_q    <= btn_level_d;
         toggle_pulse_q <= toggle_pulse_d;
         press_count_q  <= press_count_d;
      end
   end

   // Next-state and debounce counter: a check state advances while the
   // sample stays at the candidate level and falls back on any revert,
   // including a revert in the very cycle the count would complete.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ena) begin
         case (state_q)
            c_ST_IDLE_LOW: begin
               if (w_s) begin
                  state_d = c_ST_CHECK_HIGH;
                  cnt_d   = c_CNT_ONE;
               end else begin
                  cnt_d   = c_CNT_ZERO;
               end
            end
            c_ST_CHECK_HIGH: begin
               if (!w_s) begin
                  state_d = c_ST_IDLE_LOW;
                  cnt_d   = c_CNT_ZERO;
               end else if (w_cnt_done) begin
                  state_d = c_ST_IDLE_HIGH;
                  cnt_d   = c_CNT_ZERO;
               end else begin
                  cnt_d   = cnt_q + c_CNT_ONE;
               end
            end
            c_ST_IDLE_HIGH: begin
               if (!w_s) begin
                  state_d = c_ST_CHECK_LOW;
                  cnt_d   = c_CNT_ONE;
               end else begin
                  cnt_d   = c_CNT_ZERO;
               end
            end
            c_ST_CHECK_LOW: begin
               if (w_s) begin
                  state_d = c_ST_IDLE_HIGH;
                  cnt_d   = c_CNT_ZERO;
               end else if (w_cnt_done) begin
                  state_d = c_ST_IDLE_LOW;
                  cnt_d   = c_CNT_ZERO;
               end else begin
                  cnt_d   = cnt_q + c_CNT_ONE;
               end
            end
            default: begin
               state_d = c_ST_IDLE_LOW;
               cnt_d   = c_CNT_ZERO;
            end
         endcase
      end
   end

   // Output next values: only a completed rise pulses and counts; a completed
   // fall just drops the level. The pulse defaults low every cycle.
   always_comb begin
      btn_level_d    = btn_level_q;
      toggle_pulse_d = 1'b0;
      press_count_d  = press_count_q;
      if (ena) begin
         if ((state_q == c_ST_CHECK_HIGH) && w_s && w_cnt_done) begin
            btn_level_d    = 1'b1;
            toggle_pulse_d = 1'b1;
            press_count_d  = press_count_q + 8'd1;
         end else if ((state_q == c_ST_CHECK_LOW) && !w_s && w_cnt_done) begin
            btn_level_d    = 1'b0;
         end
      end
   end

   assign btn_level    = btn_level_q;
   assign toggle_pulse = toggle_pulse_q;
   assign press_count  = press_count_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_pulse_debouncer
//  Description : Self-checking bench for toggle_pulse_debouncer. One instance
//                uses DEBOUNCE_CYCLES=4, a second uses DEBOUNCE_CYCLES=1 for
//                the counter wrap scenario. A run-length reference model
//                predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_debouncer;

   localparam int S  = 2;
   localparam int D4 = 4;
   localparam int D1 = 1;
   localparam int LAT4 = S + D4 + 1;

   logic       clk = 1'b0;
   logic       rst_n, ena, btn4, btn1;
   logic       lvl4, pul4, lvl1, pul1;
   logic [7:0] pc4, pc1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   toggle_pulse_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D4), .CNT_WIDTH(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn4),
      .btn_level(lvl4), .toggle_pulse(pul4), .press_count(pc4));

   toggle_pulse_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D1), .CNT_WIDTH(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn1),
      .btn_level(lvl1), .toggle_pulse(pul1), .press_count(pc1));

   // Reference model: s is the raw input delayed S edges; the level flips once
   // D+1 consecutive enabled samples of s differ from it. A flip to 1 pulses
   // and counts.
   bit [S-1:0] m_sync  [2];
   int         m_run   [2];
   bit         m_level [2];
   bit         m_pulse [2];
   bit [7:0]   m_cnt   [2];
   int         m_d     [2] = '{D4, D1};

   task automatic model_step(input int k, input bit b);
      bit s_old;
      if (!rst_n) begin
         m_sync[k] = '0; m_run[k] = 0; m_level[k] = 0; m_pulse[k] = 0; m_cnt[k] = 0;
      end else begin
         s_old = m_sync[k][S-1];
         m_sync[k] = {m_sync[k][S-2:0], b};
         m_pulse[k] = 0;
         if (ena) begin
            if (s_old != m_level[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == m_d[k] + 1) begin
                  m_level[k] = s_old;
                  m_run[k]   = 0;
                  if (s_old) begin
                     m_pulse[k] = 1;
                     m_cnt[k]   = m_cnt[k] + 8'd1;
                  end
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
   endtask

   // One clock edge: advance the model with the inputs the DUT sampled, then
   // settle 1 time unit before anything is observed.
   task automatic tick();
      @(posedge clk);
      model_step(0, btn4);
      model_step(1, btn1);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; btn4 = 1'b1; btn1 = 1'b0;
      tick(); tick();
      checks++;
      if ({lvl4, pul4, pc4} !== 10'd0) begin
         failures++;
         $display("FAIL reset_state got lvl=%b pul=%b cnt=%0d want 0 0 0", lvl4, pul4, pc4);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= LAT4; e++) begin
         tick();
         checks++;
         if (lvl4 !== (e == LAT4) || pul4 !== (e == LAT4) || pc4 !== ((e == LAT4) ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL reset_release edge=%0d got lvl=%b pul=%b cnt=%0d want lvl=%b pul=%b cnt=%0d",
                     e, lvl4, pul4, pc4, (e == LAT4), (e == LAT4), (e == LAT4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [7:0] pc0;
      btn4 = 1'b0;
      repeat (12) tick();
      pc0 = pc4;
      checks++;
      if (lvl4 !== 1'b0 || pc0 !== 8'd1) begin
         failures++;
         $display("FAIL clean_settle got lvl=%b cnt=%0d want lvl=0 cnt=1", lvl4, pc0);
      end
      btn4 = 1'b1;
      for (int e = 1; e <= LAT4 + 1; e++) begin
         tick();
         checks++;
         if (pul4 !== (e == LAT4) || lvl4 !== (e >= LAT4)) begin
            failures++;
            $display("FAIL clean_press edge=%0d got lvl=%b pul=%b want lvl=%b pul=%b",
                     e, lvl4, pul4, (e >= LAT4), (e == LAT4));
         end
      end
      btn4 = 1'b0;
      for (int e = 1; e <= LAT4; e++) begin
         tick();
         checks++;
         if (pul4 !== 1'b0 || lvl4 !== (e < LAT4) || pc4 !== pc0 + 8'd1) begin
            failures++;
            $display("FAIL clean_release edge=%0d got lvl=%b pul=%b cnt=%0d want lvl=%b pul=0 cnt=%0d",
                     e, lvl4, pul4, pc4, (e < LAT4), pc0 + 8'd1);
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pc0;
      bit         pat[];
      int         pulses;
      pc0 = pc4;
      pat = '{1,1,1,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0};
      foreach (pat[i]) begin
         btn4 = pat[i];
         tick();
         checks++;
         if (pul4 !== 1'b0 || lvl4 !== 1'b0 || pc4 !== pc0) begin
            failures++;
            $display("FAIL bounce_reject step=%0d got lvl=%b pul=%b cnt=%0d want lvl=0 pul=0 cnt=%0d",
                     i, lvl4, pul4, pc4, pc0);
         end
      end
      pat = '{1,0,1,0,1,1,1,1,1,1,1,1,1,1,1,1};
      pulses = 0;
      foreach (pat[i]) begin
         btn4 = pat[i];
         tick();
         if (pul4 === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1 || pc4 !== pc0 + 8'd1 || lvl4 !== 1'b1) begin
         failures++;
         $display("FAIL bounce_settle got pulses=%0d cnt=%0d lvl=%b want pulses=1 cnt=%0d lvl=1",
                  pulses, pc4, lvl4, pc0 + 8'd1);
      end
   endtask

   task automatic test_enable_freeze();
      int wait_cnt;
      int pulses;
      btn4 = 1'b0;
      repeat (12) tick();
      btn4 = 1'b1;
      repeat (4) tick();      // now mid CHECK_HIGH with two samples counted
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (pul4 !== 1'b0 || lvl4 !== 1'b0) begin
            failures++;
            $display("FAIL freeze_hold cyc=%0d got lvl=%b pul=%b want 0 0", i, lvl4, pul4);
         end
      end
      ena = 1'b1;
      wait_cnt = 0;
      pulses   = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (pul4 === 1'b1) begin
            pulses++;
            if (wait_cnt == 0) wait_cnt = i;
         end
      end
      checks++;
      if (wait_cnt != D4 - 1 || pulses != 1) begin
         failures++;
         $display("FAIL freeze_resume got latency=%0d pulses=%0d want latency=%0d pulses=1",
                  wait_cnt, pulses, D4 - 1);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      btn4 = 1'b0;
      repeat (12) tick();
      btn4 = 1'b1;
      repeat (5) tick();      // counter at 3 in CHECK_HIGH
      rst_n = 1'b0;
      tick();
      checks++;
      if ({lvl4, pul4, pc4} !== 10'd0) begin
         failures++;
         $display("FAIL reset_mid_state got lvl=%b pul=%b cnt=%0d want 0 0 0", lvl4, pul4, pc4);
      end
      rst_n = 1'b1;
      lat = 0;
      for (int e = 1; e <= 20 && lat == 0; e++) begin
         tick();
         if (pul4 === 1'b1) lat = e;
      end
      checks++;
      if (lat != LAT4 || pc4 !== 8'd1) begin
         failures++;
         $display("FAIL reset_mid_latency got latency=%0d cnt=%0d want latency=%0d cnt=1", lat, pc4, LAT4);
      end
   endtask

   task automatic test_wrap();
      int  pulses;
      int  doubles;
      logic prev;
      rst_n = 1'b0; btn4 = 1'b0; btn1 = 1'b0;
      tick();
      rst_n = 1'b1;
      pulses = 0; doubles = 0; prev = 1'b0;
      for (int p = 1; p <= 257; p++) begin
         for (int ph = 0; ph < 2; ph++) begin
            btn1 = (ph == 0);
            repeat (5) begin
               tick();
               if (pul1 === 1'b1) pulses++;
               if (pul1 === 1'b1 && prev === 1'b1) doubles++;
               prev = pul1;
            end
            if (ph == 0 && p >= 255) begin
               checks++;
               if (pc1 !== 8'(p)) begin
                  failures++;
                  $display("FAIL wrap_count press=%0d got cnt=%0d want %0d", p, pc1, p % 256);
               end
            end
         end
      end
      checks++;
      if (pulses != 257 || doubles != 0) begin
         failures++;
         $display("FAIL wrap_pulses got pulses=%0d doubles=%0d want pulses=257 doubles=0", pulses, doubles);
      end
   endtask

   task automatic test_random();
      int   len4, len1;
      logic prev4, prev1;
      len4 = 0; len1 = 0; prev4 = 1'b0; prev1 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (len4 == 0) begin btn4 = 1'($urandom_range(0, 1)); len4 = $urandom_range(1, 9); end
         if (len1 == 0) begin btn1 = 1'($urandom_range(0, 1)); len1 = $urandom_range(1, 4); end
         len4--; len1--;
         ena   = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 499) != 0);
         tick();
         checks++;
         if ({lvl4, pul4, pc4} !== {m_level[0], m_pulse[0], m_cnt[0]} || (pul4 && prev4)) begin
            failures++;
            $display("FAIL random_d4 cyc=%0d got lvl=%b pul=%b cnt=%0d want lvl=%b pul=%b cnt=%0d",
                     c, lvl4, pul4, pc4, m_level[0], m_pulse[0], m_cnt[0]);
         end
         checks++;
         if ({lvl1, pul1, pc1} !== {m_level[1], m_pulse[1], m_cnt[1]} || (pul1 && prev1)) begin
            failures++;
            $display("FAIL random_d1 cyc=%0d got lvl=%b pul=%b cnt=%0d want lvl=%b pul=%b cnt=%0d",
                     c, lvl1, pul1, pc1, m_level[1], m_pulse[1], m_cnt[1]);
         end
         prev4 = pul4; prev1 = pul1;
      end
      rst_n = 1'b1; ena = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; btn4 = 1'b0; btn1 = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_enable_freeze();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/toggle_pulse_debouncer.md
Name: toggle_pulse_debouncer

Overview:
- Input conditioning stage directly upstream of the T flip-flop.
- Takes a raw, bouncy, asynchronous push-button level from a `ui_in` pin and synchronises and debounces it.
- Emits a single-cycle `toggle_pulse` per clean press; this pulse drives the flip-flop's T input, so one press gives exactly one toggle.
- Also exposes the debounced level and a wrapping press counter for observation on spare outputs.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `btn_in`; must be >= 2.
- DEBOUNCE_CYCLES, 50000, extra consecutive stable samples needed to accept a level change; must be >= 1.
- CNT_WIDTH, 16, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  design enable; low freezes the debounce FSM.
- btn_in  input  1  raw asynchronous button level, active-high.
- btn_level  output  1  debounced button level.
- toggle_pulse  output  1  one-cycle pulse on each accepted 0->1 transition; feeds T.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset: synchronous. On any rising edge with rst_n=0:
  - all synchroniser flops = 0, state = IDLE_LOW, counter = 0;
  - btn_level = 0, toggle_pulse = 0, press_count = 0.
- Reset overrides `ena`. Reset mid-check discards the partial count.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Synchroniser:
  - `btn_in` passes through a SYNC_STAGES flop chain. Call its output `s`.
  - The chain always shifts when not in reset, regardless of `ena`.
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. Evaluated only when ena=1; when ena=0, state, counter, btn_level and press_count hold, and toggle_pulse is 0.
- IDLE_LOW:
  - s=1 -> CHECK_HIGH, cnt <= 1.
  - Otherwise stay, cnt <= 0.
- CHECK_HIGH:
  - s=0 -> IDLE_LOW, cnt <= 0 (glitch rejected, no output change).
  - s=1 and cnt == DEBOUNCE_CYCLES -> IDLE_HIGH, cnt <= 0, btn_level <= 1, toggle_pulse <= 1, press_count <= press_count+1.
  - Otherwise cnt <= cnt+1.
- IDLE_HIGH and CHECK_LOW mirror the above with s inverted. Completing CHECK_LOW sets btn_level <= 0 with no pulse and no count change.
- toggle_pulse:
  - 1 for exactly one cycle per accepted rise; default 0 in every other cycle.
  - Can never be high in two consecutive cycles, since the earliest next pulse needs a full low acceptance plus a full high acceptance.
- Latency from btn_in rising (stable before edge 1) to btn_level/toggle_pulse high = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges. Release latency is identical.
- Acceptance needs DEBOUNCE_CYCLES+1 consecutive samples of s at the new value. Any excursion of <= DEBOUNCE_CYCLES samples is ignored.
- press_count wraps 255 -> 0 on the 256th press; no saturation, no flag.
- Simultaneous events:
  - A bounce sample in the same cycle the count would complete counts as a revert: no acceptance.
  - ena falling mid-check pauses the count; it resumes on ena=1 from the held value.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: drive rst_n=0 for 2 edges with btn_in=1 -> btn_level=0, toggle_pulse=0, press_count=0. Release with btn_in held 1 -> btn_level rises at edge 7 after release, press_count=1.
- Clean press: btn_in 0->1 before edge 1 and held -> toggle_pulse=1 only in the cycle after edge 7, btn_level=1 from edge 7. Release identically -> btn_level=0 seven edges later, no pulse, press_count unchanged.
- Bounce rejection: btn_in high 3 cycles, low 1, high 4, low -> no pulse, btn_level stays 0, press_count=0. Then 1010 pattern ending high and held -> exactly one pulse.
- Enable freeze: start a press, drop ena for 10 cycles mid-CHECK_HIGH, keep btn_in=1 -> no pulse while ena=0. After ena=1, pulse after the remaining count, single pulse only.
- Wrap: 257 clean press/release cycles (DEBOUNCE_CYCLES=1 to shorten) -> press_count reads 255, then 0, then 1. Exactly 257 toggle_pulse assertions, never two consecutive.
- Reset mid-operation: assert rst_n=0 at cnt=3 in CHECK_HIGH -> next edge: state IDLE_LOW, all outputs 0. After release with btn_in still 1, full SYNC_STAGES+DEBOUNCE_CYCLES+1 latency is required again before the pulse.
